// File: rtl/lane_engine_pkg.sv
// Shared types and default geometry for the lane engine.
package lane_engine_pkg;

  typedef enum logic {
    LANE_IDLE = 1'b0,
    LANE_FALL = 1'b1
  } lane_state_e;

  localparam int unsigned DEF_NUM_LANES = 4;
  localparam int unsigned DEF_Y_W       = 10;
  localparam int unsigned DEF_SPEED     = 5;
  localparam int unsigned DEF_SPAWN_Y   = 50;
  localparam int unsigned DEF_BLK_H     = 50;
  localparam int unsigned DEF_HIT_LO    = 600;
  localparam int unsigned DEF_HIT_HI    = 650;
  localparam int unsigned DEF_BOTTOM    = 720;

  localparam int unsigned SCORE_W = 16;
  localparam int unsigned COMBO_W = 8;

endpackage

// File: rtl/lane_engine_lane_ctrl.sv
// One note lane: button edge detect, IDLE/FALL state machine and block position.
// LANE_ENGINE_GHOST_PENALTY_EN enables reporting of ghost presses to the top.
module lane_ctrl
  import lane_engine_pkg::*;
#(
  parameter int unsigned Y_W     = DEF_Y_W,
  parameter int unsigned SPEED   = DEF_SPEED,
  parameter int unsigned SPAWN_Y = DEF_SPAWN_Y,
  parameter int unsigned BLK_H   = DEF_BLK_H,
  parameter int unsigned HIT_LO  = DEF_HIT_LO,
  parameter int unsigned HIT_HI  = DEF_HIT_HI,
  parameter int unsigned BOTTOM  = DEF_BOTTOM
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_tick,
  input  logic           i_spawn,
  input  logic           i_userin,
  output logic [Y_W-1:0] o_top,
  output logic [Y_W-1:0] o_bot,
  output logic           o_active,
  output logic           o_hit,
  output logic           o_miss,
  output logic           o_hit_nxt,
  output logic           o_miss_nxt,
  output logic           o_ghost
);

  localparam logic [Y_W-1:0] L_TOP0   = Y_W'(SPAWN_Y);
  localparam logic [Y_W-1:0] L_BOT0   = Y_W'(SPAWN_Y + BLK_H);
  localparam logic [Y_W-1:0] L_SPEED  = Y_W'(SPEED);
  localparam logic [Y_W-1:0] L_HIT_LO = Y_W'(HIT_LO);
  localparam logic [Y_W-1:0] L_HIT_HI = Y_W'(HIT_HI);
  localparam logic [Y_W-1:0] L_BOTTOM = Y_W'(BOTTOM);

  lane_state_e    r_state, w_state_nxt;
  logic           r_prev;
  logic [Y_W-1:0] r_top, r_bot, w_top_nxt, w_bot_nxt;
  logic           r_hit, r_miss;
  logic           w_press, w_in_win, w_hit_nxt, w_miss_nxt;

  assign w_press  = i_userin & ~r_prev;
  assign w_in_win = (r_bot >= L_HIT_LO) && (r_bot < L_HIT_HI);

  // A hit wins over a same-cycle tick, so a miss is only possible without a hit.
  always_comb begin
    w_state_nxt = r_state;
    w_top_nxt   = r_top;
    w_bot_nxt   = r_bot;
    w_hit_nxt   = 1'b0;
    w_miss_nxt  = 1'b0;
    case (r_state)
      LANE_IDLE: begin
        if (i_spawn) w_state_nxt = LANE_FALL;
      end
      LANE_FALL: begin
        if (w_press && w_in_win) begin
          w_hit_nxt   = 1'b1;
          w_state_nxt = LANE_IDLE;
          w_top_nxt   = L_TOP0;
          w_bot_nxt   = L_BOT0;
        end else if (i_tick) begin
          if (r_bot >= L_BOTTOM) begin
            w_miss_nxt  = 1'b1;
            w_state_nxt = LANE_IDLE;
            w_top_nxt   = L_TOP0;
            w_bot_nxt   = L_BOT0;
          end else begin
            w_top_nxt = r_top + L_SPEED;
            w_bot_nxt = r_bot + L_SPEED;
          end
        end
      end
      default: w_state_nxt = LANE_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    r_prev <= i_userin;
    if (i_reset) begin
      r_state <= LANE_IDLE;
      r_top   <= L_TOP0;
      r_bot   <= L_BOT0;
      r_hit   <= 1'b0;
      r_miss  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_top   <= w_top_nxt;
      r_bot   <= w_bot_nxt;
      r_hit   <= w_hit_nxt;
      r_miss  <= w_miss_nxt;
    end
  end

`ifdef LANE_ENGINE_GHOST_PENALTY_EN
  assign o_ghost = w_press & ~((r_state == LANE_FALL) & w_in_win);
`else
  assign o_ghost = 1'b0;
`endif

  assign o_top      = r_top;
  assign o_bot      = r_bot;
  assign o_active   = (r_state == LANE_FALL);
  assign o_hit      = r_hit;
  assign o_miss     = r_miss;
  assign o_hit_nxt  = w_hit_nxt;
  assign o_miss_nxt = w_miss_nxt;

endmodule

// File: rtl/lane_engine.sv
// Rhythm-game lane engine: NUM_LANES falling-note lanes plus score/combo accounting.
// Define LANE_ENGINE_GHOST_PENALTY_EN to make ghost presses clear the combo.
module lane_engine
  import lane_engine_pkg::*;
#(
  parameter int unsigned NUM_LANES = DEF_NUM_LANES,
  parameter int unsigned Y_W       = DEF_Y_W,
  parameter int unsigned SPEED     = DEF_SPEED,
  parameter int unsigned SPAWN_Y   = DEF_SPAWN_Y,
  parameter int unsigned BLK_H     = DEF_BLK_H,
  parameter int unsigned HIT_LO    = DEF_HIT_LO,
  parameter int unsigned HIT_HI    = DEF_HIT_HI,
  parameter int unsigned BOTTOM    = DEF_BOTTOM
) (
  input  logic                     clk_blk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic [NUM_LANES-1:0]     spawn,
  input  logic [NUM_LANES-1:0]     userin,
  output logic [NUM_LANES*Y_W-1:0] blk_top,
  output logic [NUM_LANES*Y_W-1:0] blk_bot,
  output logic [NUM_LANES-1:0]     blk_active,
  output logic [NUM_LANES-1:0]     hit,
  output logic [NUM_LANES-1:0]     miss,
  output logic [SCORE_W-1:0]       score,
  output logic [COMBO_W-1:0]       combo
);

  logic [NUM_LANES-1:0] w_hit_nxt, w_miss_nxt, w_ghost;
  logic [3:0]           w_nhit;
  logic [SCORE_W:0]     w_score_sum;
  logic [COMBO_W:0]     w_combo_sum;
  logic [SCORE_W-1:0]   r_score, w_score_nxt;
  logic [COMBO_W-1:0]   r_combo, w_combo_nxt;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_ctrl #(
      .Y_W    (Y_W),
      .SPEED  (SPEED),
      .SPAWN_Y(SPAWN_Y),
      .BLK_H  (BLK_H),
      .HIT_LO (HIT_LO),
      .HIT_HI (HIT_HI),
      .BOTTOM (BOTTOM)
    ) u_lane (
      .i_clk     (clk_blk),
      .i_reset   (reset),
      .i_tick    (tick),
      .i_spawn   (spawn[g]),
      .i_userin  (userin[g]),
      .o_top     (blk_top[g*Y_W +: Y_W]),
      .o_bot     (blk_bot[g*Y_W +: Y_W]),
      .o_active  (blk_active[g]),
      .o_hit     (hit[g]),
      .o_miss    (miss[g]),
      .o_hit_nxt (w_hit_nxt[g]),
      .o_miss_nxt(w_miss_nxt[g]),
      .o_ghost   (w_ghost[g])
    );
  end

  // Accounting uses the lanes' next-state judgements so score/combo land on the same edge as hit/miss.
  always_comb begin
    w_nhit = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) w_nhit = w_nhit + 4'(w_hit_nxt[i]);

    w_score_sum = {1'b0, r_score} + {{(SCORE_W-3){1'b0}}, w_nhit};
    w_score_nxt = w_score_sum[SCORE_W] ? '1 : w_score_sum[SCORE_W-1:0];

    w_combo_sum = {1'b0, r_combo} + {{(COMBO_W-3){1'b0}}, w_nhit};
    if (|w_miss_nxt || |w_ghost) w_combo_nxt = '0;
    else if (w_combo_sum[COMBO_W]) w_combo_nxt = '1;
    else w_combo_nxt = w_combo_sum[COMBO_W-1:0];
  end

  always_ff @(posedge clk_blk) begin
    if (reset) begin
      r_score <= '0;
      r_combo <= '0;
    end else begin
      r_score <= w_score_nxt;
      r_combo <= w_combo_nxt;
    end
  end

  assign score = r_score;
  assign combo = r_combo;

endmodule

// File: tb/tb_lane_engine.sv
// Self-checking bench for lane_engine: directed scenarios plus randomized traffic
// against a tick-count based model of each lane.
module tb_lane_engine;

  localparam int NL = 4;
  localparam int YW = 10;

  logic             clk_blk = 1'b0;
  logic             reset;
  logic             tick;
  logic [NL-1:0]    spawn;
  logic [NL-1:0]    userin;
  logic [NL*YW-1:0] blk_top, blk_bot;
  logic [NL-1:0]    blk_active, hit, miss;
  logic [15:0]      score;
  logic [7:0]       combo;

  int n_total = 0;
  int n_bad   = 0;

  lane_engine #(.NUM_LANES(NL), .Y_W(YW)) dut (
    .clk_blk   (clk_blk),
    .reset     (reset),
    .tick      (tick),
    .spawn     (spawn),
    .userin    (userin),
    .blk_top   (blk_top),
    .blk_bot   (blk_bot),
    .blk_active(blk_active),
    .hit       (hit),
    .miss      (miss),
    .score     (score),
    .combo     (combo)
  );

  always #5 clk_blk = ~clk_blk;

  // Model: a falling lane is described by how many ticks it has advanced.
  bit      m_valid = 1'b0;
  bit      m_fall [NL];
  int      m_dist [NL];
  bit      m_prev [NL];
  bit [NL-1:0] e_hit, e_miss;
  int      e_score, e_combo;
  bit      ghost_en;

  initial begin
`ifdef LANE_ENGINE_GHOST_PENALTY_EN
    ghost_en = 1'b1;
`else
    ghost_en = 1'b0;
`endif
  end

  always @(posedge clk_blk) begin
    if (reset) begin
      for (int l = 0; l < NL; l++) begin
        m_fall[l] = 1'b0;
        m_dist[l] = 0;
        m_prev[l] = userin[l];
      end
      e_hit = '0; e_miss = '0; e_score = 0; e_combo = 0;
      m_valid = 1'b1;
    end else begin
      int  nh;
      bit  any_ghost;
      nh = 0; any_ghost = 1'b0;
      for (int l = 0; l < NL; l++) begin
        bit press, inwin;
        int bot;
        press = userin[l] && !m_prev[l];
        bot   = 100 + 5 * m_dist[l];
        inwin = m_fall[l] && bot >= 600 && bot < 650;
        e_hit[l]  = m_fall[l] && press && inwin;
        e_miss[l] = m_fall[l] && !e_hit[l] && tick && bot >= 720;
        if (e_hit[l] || e_miss[l]) begin
          m_fall[l] = 1'b0; m_dist[l] = 0;
        end else if (m_fall[l] && tick) m_dist[l]++;
        else if (!m_fall[l] && spawn[l]) m_fall[l] = 1'b1;
        if (press && !inwin) any_ghost = 1'b1;
        if (e_hit[l]) nh++;
        m_prev[l] = userin[l];
      end
      e_score = (e_score + nh > 65535) ? 65535 : e_score + nh;
      if (e_miss != 0) e_combo = 0;
      else if (ghost_en && any_ghost) e_combo = 0;
      else e_combo = (e_combo + nh > 255) ? 255 : e_combo + nh;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk_blk) begin
    if (m_valid) begin
      logic [NL*YW-1:0] xt, xb;
      logic [NL-1:0]    xa;
      for (int l = 0; l < NL; l++) begin
        xt[l*YW +: YW] = YW'(50 + 5 * m_dist[l]);
        xb[l*YW +: YW] = YW'(100 + 5 * m_dist[l]);
        xa[l] = m_fall[l];
      end
      chk("blk_top", 64'(blk_top), 64'(xt));
      chk("blk_bot", 64'(blk_bot), 64'(xb));
      chk("blk_active", 64'(blk_active), 64'(xa));
      chk("hit", 64'(hit), 64'(e_hit));
      chk("miss", 64'(miss), 64'(e_miss));
      chk("score", 64'(score), 64'(e_score));
      chk("combo", 64'(combo), 64'(e_combo));
    end
  end

  task automatic cyc();
    @(posedge clk_blk);
    #1;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) cyc();
    tick = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; tick = 1'b0; spawn = '0; userin = '0;
    cyc();
    chk("rst_active", 64'(blk_active), 64'd0);
    chk("rst_bot0", 64'(blk_bot[9:0]), 64'd100);
    reset = 1'b0;

    // Test 1: single hit at the window's lower edge
    spawn = 4'b0001; cyc(); spawn = '0;
    ticks(100);
    chk("t1_bot600", 64'(blk_bot[9:0]), 64'd600);
    chk("t1_top550", 64'(blk_top[9:0]), 64'd550);
    userin = 4'b0001; cyc();
    chk("t1_hit", 64'(hit), 64'b0001);
    chk("t1_score", 64'(score), 64'd1);
    chk("t1_combo", 64'(combo), 64'd1);
    chk("t1_idle", 64'(blk_active[0]), 64'd0);
    userin = '0; cyc();
    chk("t1_hit_pulse", 64'(hit), 64'd0);

    // Test 2: unplayed block reaches the bottom
    spawn = 4'b0010; cyc(); spawn = '0;
    ticks(124);
    chk("t2_bot720", 64'(blk_bot[19:10]), 64'd720);
    chk("t2_nomiss", 64'(miss), 64'd0);
    ticks(1);
    chk("t2_miss", 64'(miss), 64'b0010);
    chk("t2_combo", 64'(combo), 64'd0);
    chk("t2_score", 64'(score), 64'd1);

    // Test 3: two lanes hit together
    spawn = 4'b0101; cyc(); spawn = '0;
    ticks(104);
    chk("t3_bot620", 64'(blk_bot[29:20]), 64'd620);
    userin = 4'b0101; cyc();
    chk("t3_hit", 64'(hit), 64'b0101);
    chk("t3_score", 64'(score), 64'd3);
    chk("t3_combo", 64'(combo), 64'd2);
    userin = '0; cyc();

    // Test 4: press just above the window
    spawn = 4'b0001; cyc(); spawn = '0;
    ticks(99);
    userin = 4'b0001; cyc();
    chk("t4_nohit", 64'(hit), 64'd0);
    chk("t4_falling", 64'(blk_active[0]), 64'd1);
    chk("t4_combo", 64'(combo), ghost_en ? 64'd0 : 64'd2);
    userin = '0; ticks(1);
    userin = 4'b0001; cyc();
    chk("t4_late_hit", 64'(hit), 64'b0001);
    userin = '0; cyc();

    // Test 5: button held through reset release
    userin = 4'b1000; reset = 1'b1; cyc(); reset = 1'b0;
    spawn = 4'b1000; cyc(); spawn = '0;
    ticks(101);
    cyc();
    chk("t5_nohit", 64'(hit), 64'd0);
    chk("t5_falling", 64'(blk_active[3]), 64'd1);
    userin = '0; cyc();
    userin = 4'b1000; cyc();
    chk("t5_hit", 64'(hit), 64'b1000);
    userin = '0; cyc();

    // Test 6: reset mid-fall, then combo saturation
    spawn = 4'b0001; cyc(); spawn = '0;
    ticks(60);
    chk("t6_bot400", 64'(blk_bot[9:0]), 64'd400);
    reset = 1'b1; tick = 1'b1; cyc(); reset = 1'b0; tick = 1'b0;
    chk("t6_idle", 64'(blk_active), 64'd0);
    chk("t6_nomiss", 64'(miss), 64'd0);
    chk("t6_bot100", 64'(blk_bot[9:0]), 64'd100);
    for (int r = 0; r < 75; r++) begin
      spawn = 4'b1111; cyc(); spawn = '0;
      ticks(100);
      userin = 4'b1111; cyc();
      userin = '0; cyc();
    end
    chk("t6_combo_sat", 64'(combo), 64'd255);
    chk("t6_score", 64'(score), 64'd300);

    // Randomized traffic
    for (int c = 0; c < 20000; c++) begin
      reset = ($urandom_range(0, 999) == 0);
      tick  = $urandom_range(0, 1);
      spawn = NL'($urandom) & NL'($urandom);
      for (int l = 0; l < NL; l++)
        if ($urandom_range(0, 7) == 0) userin[l] = ~userin[l];
      cyc();
    end

    reset = 1'b0; tick = 1'b0; spawn = '0; userin = '0;
    cyc();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
